// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the CPU MEM stage.
//
// Accepts one load or store at a time, inserts WAIT_CYCLES wait states,
// then answers with a single-cycle rsp_valid pulse. Misaligned,
// out-of-range and rd+wr requests complete with rsp_err=1 and touch no memory.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req_addr   byte address of the request
//   req_rd     load request
//   req_wr     store request
//   req_wdata  store data
//   req_be     store byte enables (bit i -> lane [8i+7:8i])
//   rsp_rdata  load data, meaningful only while rsp_valid=1
//   rsp_valid  one-cycle completion pulse
//   rsp_err    error flag, qualified by rsp_valid
//   stall      pipeline hold request (combinational)
//   rd_count, wr_count, err_count  saturating statistics
//              (present only when DMEM_STATS_EN is defined)
//
// Handshake: the requester presents req_rd|req_wr and keeps it steady while
// stall=1. A request is accepted on the first IDLE cycle it is seen; stall
// stays high through the wait states and drops in the response cycle, where
// rsp_valid=1. The requester must withdraw (or replace) the request during
// the response cycle, because a request still present then is re-sampled in
// the following IDLE cycle and accepted as a new access.
//
// The internal `state` signal is left visible for checkers and debug.
//
// Optional feature macro: DMEM_STATS_EN.

module dmem_responder #(
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] req_addr,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic [31:0] rsp_rdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic        stall
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] err_count
`endif
);

  // Elaboration-time parameter checks.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end
  if (AW < 1 || AW > 29) begin : g_bad_aw
    $error("dmem_responder: AW must be in 1..29");
  end

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  // Latched copy of the accepted request.
  logic [31:0] lat_addr;
  logic        lat_rd;
  logic        lat_wr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic [31:0] mem [2**AW];

  logic        req_present;
  logic        accept;
  logic        commit;
  logic [31:0] eff_addr;
  logic        eff_rd;
  logic        eff_wr;
  logic [31:0] eff_wdata;
  logic [3:0]  eff_be;
  logic        eff_err;
  logic [AW-1:0] eff_idx;

  assign req_present = req_rd | req_wr;
  assign accept      = (state == IDLE) && req_present;

  // With zero wait states the access commits on the same edge that accepts
  // it, so the bus values are used directly; otherwise the latched copy.
  assign eff_addr  = accept ? req_addr  : lat_addr;
  assign eff_rd    = accept ? req_rd    : lat_rd;
  assign eff_wr    = accept ? req_wr    : lat_wr;
  assign eff_wdata = accept ? req_wdata : lat_wdata;
  assign eff_be    = accept ? req_be    : lat_be;

  assign eff_idx = eff_addr[AW+1:2];
  assign eff_err = (eff_addr[1:0] != 2'b00)
                 || ((eff_addr >> (AW + 2)) != 32'd0)
                 || (eff_rd && eff_wr);

  // The access takes effect on the edge that enters RESP; a reset on that
  // same edge abandons it.
  assign commit = (state_next == RESP) && !reset;

  assign stall = accept || (state == WAIT);

  // Next-state logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req_present) begin
          cnt_next   = WAIT_INIT;
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // cnt is at least 1 here, so the decrement never wraps.
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, latch and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_addr  <= 32'd0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        lat_addr  <= req_addr;
        lat_rd    <= req_rd;
        lat_wr    <= req_wr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end
      rsp_valid <= commit;
      rsp_err   <= commit && eff_err;
      if (commit && eff_rd && !eff_err) begin
        rsp_rdata <= mem[eff_idx];
      end else begin
        rsp_rdata <= 32'd0;
      end
    end
  end

  // Memory array: not cleared by reset.
  always_ff @(posedge clk) begin
    if (commit && eff_wr && !eff_err) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_be[i]) begin
          mem[eff_idx][i*8 +: 8] <= eff_wdata[i*8 +: 8];
        end
      end
    end
  end

`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic [15:0] err_cnt;

  // Counted in the response cycle from the latched request; saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt  <= 16'd0;
      wr_cnt  <= 16'd0;
      err_cnt <= 16'd0;
    end else if (state == RESP) begin
      if (rsp_err) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end else if (lat_rd) begin
        if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      end else if (lat_wr) begin
        if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      end
    end
  end

  assign rd_count  = rd_cnt;
  assign wr_count  = wr_cnt;
  assign err_count = err_cnt;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// Instance dut uses WAIT_CYCLES=2, instance dut0 uses WAIT_CYCLES=0.

module tb_dmem_responder;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // dut (WAIT_CYCLES=2) signals.
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        req_rd, req_wr, rsp_valid, rsp_err, stall;
  logic [3:0]  req_be;

  // dut0 (WAIT_CYCLES=0) signals.
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic        z_rd, z_wr, z_valid, z_err, z_stall;
  logic [3:0]  z_be;

`ifdef DMEM_STATS_EN
  logic [15:0] rd_count, wr_count, err_count;
  logic [15:0] z_rd_count, z_wr_count, z_err_count;
`endif

  dmem_responder #(.AW(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_addr(req_addr), .req_rd(req_rd), .req_wr(req_wr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_rdata(rsp_rdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .stall(stall)
`ifdef DMEM_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
`endif
  );

  dmem_responder #(.AW(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_addr(z_addr), .req_rd(z_rd), .req_wr(z_wr),
    .req_wdata(z_wdata), .req_be(z_be),
    .rsp_rdata(z_rdata), .rsp_valid(z_valid), .rsp_err(z_err),
    .stall(z_stall)
`ifdef DMEM_STATS_EN
    , .rd_count(z_rd_count), .wr_count(z_wr_count), .err_count(z_err_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one request on dut, hold it while stalled, drop it in the
  // response cycle. Returns data, error, cycles-to-response and stall count.
  task automatic txn(input logic [31:0] a, input logic rd, input logic wr,
                     input logic [31:0] wd, input logic [3:0] be,
                     output logic [31:0] rdata, output logic err,
                     output int lat, output int stalls);
    req_addr = a; req_rd = rd; req_wr = wr; req_wdata = wd; req_be = be;
    lat = 0; stalls = 0; rdata = 32'hxxxx_xxxx; err = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rdata = rsp_rdata;
        err   = rsp_err;
        chk("stall_low_in_resp", 32'(stall), 32'd0);
        break;
      end
      if (stall) stalls++;
      @(posedge clk);
      #1;
      lat++;
    end
    req_rd = 1'b0; req_wr = 1'b0;
    next_cycle();
  endtask

  // Transaction plus checks of data, error, latency and stall length.
  task automatic access(input string tag, input logic [31:0] a, input logic rd,
                        input logic wr, input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] d;
    logic        e;
    int          lat, st;
    txn(a, rd, wr, wd, be, d, e, lat, st);
    chk({tag, "_rdata"}, d, exp_data);
    chk({tag, "_err"}, 32'(e), 32'(exp_err));
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    chk({tag, "_stall_cycles"}, 32'(st), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int seen;
    reset = 1'b1;
    req_addr = '0; req_rd = 1'b0; req_wr = 1'b0; req_wdata = '0; req_be = '0;
    z_addr = '0; z_rd = 1'b0; z_wr = 1'b0; z_wdata = '0; z_be = '0;
    repeat (3) next_cycle();

    // Reset state.
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err",   32'(rsp_err),   32'd0);
    chk("reset_rsp_rdata", rsp_rdata,      32'd0);
    chk("reset_stall",     32'(stall),     32'd0);
    chk("reset_state",     32'(dut.state), 32'd0);
    chk("reset_z_valid",   32'(z_valid),   32'd0);
    reset = 1'b0;
    next_cycle();

    // 1: store then load back.
    access("t1_store", 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    access("t1_load",  32'h10, 1'b1, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // 2: partial byte-enable store merges with the old word.
    access("t2_store_full", 32'h20, 1'b0, 1'b1, 32'h11223344, 4'hF, 32'h0, 1'b0);
    access("t2_store_part", 32'h20, 1'b0, 1'b1, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    access("t2_load",       32'h20, 1'b1, 1'b0, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

    // 3: error cases, then memory at 0x20 unchanged.
    access("t3_misaligned", 32'h22,  1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    access("t3_out_range",  32'h400, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    access("t3_rd_wr",      32'h20,  1'b1, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    access("t3_oor_store",  32'h420, 1'b0, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    access("t3_be_zero",    32'h20,  1'b0, 1'b1, 32'h0BADF00D, 4'h0, 32'h0, 1'b0);
    access("t3_load_check", 32'h20,  1'b1, 1'b0, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

    // 4: reset during the first wait cycle abandons the store.
    access("t4_prior", 32'h30, 1'b0, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    req_addr = 32'h30; req_wr = 1'b1; req_wdata = 32'h5; req_be = 4'hF;
    @(negedge clk);
    chk("t4_stall_accept", 32'(stall), 32'd1);
    next_cycle();
    chk("t4_in_wait", 32'(dut.state), 32'd1);
    reset = 1'b1;
    req_wr = 1'b0;
    next_cycle();
    chk("t4_state_idle", 32'(dut.state), 32'd0);
    chk("t4_no_valid",   32'(rsp_valid), 32'd0);
    chk("t4_no_stall",   32'(stall),     32'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
      next_cycle();
    end
    chk("t4_no_late_valid", 32'(seen), 32'd0);
    access("t4_load", 32'h30, 1'b1, 1'b0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

    // 5: zero wait states on dut0, back-to-back re-acceptance.
    z_addr = 32'h40; z_wr = 1'b1; z_wdata = 32'h0BADCAFE; z_be = 4'hF;
    @(negedge clk);
    chk("t5_store_stall", 32'(z_stall), 32'd1);
    chk("t5_store_noval", 32'(z_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t5_store_valid", 32'(z_valid), 32'd1);
    chk("t5_store_err",   32'(z_err),   32'd0);
    z_wr = 1'b0;
    next_cycle();
    z_rd = 1'b1;
    @(negedge clk);
    chk("t5_T_stall", 32'(z_stall), 32'd1);
    chk("t5_T_valid", 32'(z_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t5_T1_valid", 32'(z_valid), 32'd1);
    chk("t5_T1_stall", 32'(z_stall), 32'd0);
    chk("t5_T1_rdata", z_rdata, 32'h0BADCAFE);
    next_cycle();
    @(negedge clk);
    chk("t5_T2_stall", 32'(z_stall), 32'd1);
    chk("t5_T2_valid", 32'(z_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t5_T3_valid", 32'(z_valid), 32'd1);
    chk("t5_T3_rdata", z_rdata, 32'h0BADCAFE);
    z_rd = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("t5_idle_after", 32'(z_stall), 32'd0);
    next_cycle();

`ifdef DMEM_STATS_EN
    // 6: statistics counters.
    reset = 1'b1;
    repeat (2) next_cycle();
    reset = 1'b0;
    chk("t6_rd_reset",  32'(rd_count),  32'd0);
    chk("t6_wr_reset",  32'(wr_count),  32'd0);
    chk("t6_err_reset", 32'(err_count), 32'd0);
    next_cycle();
    access("t6_ld0", 32'h10, 1'b1, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    access("t6_ld1", 32'h20, 1'b1, 1'b0, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
    access("t6_ld2", 32'h30, 1'b1, 1'b0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
    access("t6_st0", 32'h50, 1'b0, 1'b1, 32'h1, 4'hF, 32'h0, 1'b0);
    access("t6_st1", 32'h54, 1'b0, 1'b1, 32'h2, 4'hF, 32'h0, 1'b0);
    access("t6_mis", 32'h13, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    next_cycle();
    chk("t6_rd_count",  32'(rd_count),  32'd3);
    chk("t6_wr_count",  32'(wr_count),  32'd2);
    chk("t6_err_count", 32'(err_count), 32'd1);

    force dut0.err_cnt = 16'hFFFF;
    next_cycle();
    release dut0.err_cnt;
    chk("t6_preload", 32'(z_err_count), 32'h0000FFFF);
    z_addr = 32'h1; z_rd = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("t6_z_err_pulse", 32'(z_err), 32'd1);
    z_rd = 1'b0;
    next_cycle();
    next_cycle();
    chk("t6_err_saturate", 32'(z_err_count), 32'h0000FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
